// File: rtl/weight_fetch_ctrl.sv
// Weight BRAM read initiator: issues COUNT reads from BASE, lands them in a credit-limited
// skid FIFO and streams them over valid/ready. Define WFETCH_RANGE_CHECK_EN to add ERR.
module weight_fetch_ctrl #(
    parameter int AW         = 5,
    parameter int DW         = 16,
    parameter int DEPTH      = 28,
    parameter int RD_LAT     = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic          START,
    input  logic [AW-1:0] BASE,
    input  logic [AW:0]   COUNT,
    output logic [AW-1:0] BRAM_ADDR,
    output logic          BRAM_EN,
    output logic          BRAM_WE,
    input  logic [DW-1:0] BRAM_DO,
    output logic [DW-1:0] W_DATA,
    output logic          W_VALID,
    input  logic          W_READY,
    output logic          W_LAST,
    output logic          BUSY,
    output logic          DONE
`ifdef WFETCH_RANGE_CHECK_EN
    ,
    output logic          ERR
`endif
);

    localparam int PW  = (RD_LAT > 1) ? RD_LAT - 1 : 1;
    localparam int FAW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int OW  = $clog2(FIFO_DEPTH + 1);
    localparam int CW  = OW + 1;
    localparam int XW  = AW + 2;

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, FIN} state_t;

    state_t         state_q, state_d;
    logic [AW-1:0]  ptr_q, ptr_d;
    logic [AW:0]    count_q, count_d;
    logic [AW:0]    issued_q, issued_d;
    logic [AW:0]    deliv_q, deliv_d;
    logic [PW-1:0]  vld_q, vld_d;
    logic [FAW-1:0] wr_ptr_q, wr_ptr_d;
    logic [FAW-1:0] rd_ptr_q, rd_ptr_d;
    logic [OW-1:0]  occ_q, occ_d;
    logic [DW-1:0]  fifo_q [FIFO_DEPTH];
    logic [DW-1:0]  fifo_d [FIFO_DEPTH];
`ifdef WFETCH_RANGE_CHECK_EN
    logic           err_q, err_d;
    logic           range_bad;
`endif

    logic [CW-1:0]  inflight;
    logic           issue;
    logic           push;
    logic           pop;

    function automatic logic [FAW-1:0] fifo_inc(input logic [FAW-1:0] p);
        return (p == FAW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        state_d  = state_q;
        ptr_d    = ptr_q;
        count_d  = count_q;
        issued_d = issued_q;
        deliv_d  = deliv_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        fifo_d   = fifo_q;
`ifdef WFETCH_RANGE_CHECK_EN
        err_d     = err_q;
        range_bad = ({2'b00, BASE} >= XW'(DEPTH)) ||
                    (({2'b00, BASE} + {1'b0, COUNT}) > XW'(DEPTH));
`endif

        // Reads still travelling through the BRAM pipeline hold a FIFO slot in advance.
        inflight = '0;
        for (int i = 0; i < PW; i++) begin
            if (i < RD_LAT - 1) inflight = inflight + CW'(vld_q[i]);
        end

        issue = (state_q == FETCH) && (issued_q < count_q) &&
                ((inflight + CW'(occ_q)) < CW'(FIFO_DEPTH));
        vld_d = PW'({vld_q, issue});
        push  = (RD_LAT == 1) ? issue : vld_q[PW-1];
        pop   = (occ_q != '0) && W_READY;

        if (push) begin
            fifo_d[wr_ptr_q] = BRAM_DO;
            wr_ptr_d         = fifo_inc(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = fifo_inc(rd_ptr_q);
            deliv_d  = deliv_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   occ_d = occ_q + 1'b1;
            2'b01:   occ_d = occ_q - 1'b1;
            default: occ_d = occ_q;
        endcase

        unique case (state_q)
            IDLE: begin
                if (START) begin
                    ptr_d    = BASE;
                    count_d  = COUNT;
                    issued_d = '0;
                    deliv_d  = '0;
`ifdef WFETCH_RANGE_CHECK_EN
                    err_d    = range_bad;
                    state_d  = (range_bad || COUNT == '0) ? FIN : FETCH;
`else
                    state_d  = (COUNT == '0) ? FIN : FETCH;
`endif
                end
            end
            FETCH: begin
                if (issue) begin
                    ptr_d    = (ptr_q == AW'(DEPTH - 1)) ? '0 : ptr_q + 1'b1;
                    issued_d = issued_q + 1'b1;
                    if (issued_q + 1'b1 == count_q) state_d = DRAIN;
                end
            end
            // Look at the post-pop count so DONE follows the last word by one cycle.
            DRAIN:   if (deliv_d == count_q) state_d = FIN;
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            count_q  <= '0;
            issued_q <= '0;
            deliv_q  <= '0;
            vld_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
`ifdef WFETCH_RANGE_CHECK_EN
            err_q    <= 1'b0;
`endif
            // NOTE: the skid storage is reset too, so W_DATA reads 0 straight out of reset.
            for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
        end else begin
            // NOTE: non-blocking updates make every flop sample pre-edge values.
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            count_q  <= count_d;
            issued_q <= issued_d;
            deliv_q  <= deliv_d;
            vld_q    <= vld_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
`ifdef WFETCH_RANGE_CHECK_EN
            err_q    <= err_d;
`endif
            fifo_q   <= fifo_d;
        end
    end

    assign BRAM_ADDR = ptr_q;
    assign BRAM_EN   = issue;
    assign BRAM_WE   = 1'b0;
    assign W_DATA    = fifo_q[rd_ptr_q];
    assign W_VALID   = (occ_q != '0);
    assign W_LAST    = W_VALID && (deliv_q == count_q - 1'b1);
    assign BUSY      = (state_q == FETCH) || (state_q == DRAIN);
    assign DONE      = (state_q == FIN);
`ifdef WFETCH_RANGE_CHECK_EN
    assign ERR       = err_q;
`endif

endmodule

// File: tb/tb_weight_fetch_ctrl.sv
// Directed bench for weight_fetch_ctrl: BRAM model, stream monitor with a FIFO credit model,
// and hand-computed expectations for each request.
`timescale 1ns/1ps
module tb_weight_fetch_ctrl;

    localparam int AW    = 5;
    localparam int DW    = 16;
    localparam int DEPTH = 28;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [AW-1:0] base;
    logic [AW:0]   count;
    logic [AW-1:0] bram_addr;
    logic          bram_en;
    logic          bram_we;
    logic [DW-1:0] bram_do;
    logic [DW-1:0] w_data;
    logic          w_valid;
    logic          w_ready;
    logic          w_last;
    logic          busy;
    logic          done;
`ifdef WFETCH_RANGE_CHECK_EN
    logic          err;
`endif

    int errors = 0;
    int checks = 0;

    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] got_q [$];
    bit            last_q [$];
    int            pop_cyc [$];
    logic [AW-1:0] addr_q [$];
    int            en_cnt    = 0;
    int            done_cnt  = 0;
    int            done_cyc  = 0;
    int            cyc       = 0;
    int            model_occ = 0;
    bit            stalled_prev = 0;
    logic [DW-1:0] prev_data = '0;
    bit            bp_pat [6] = '{1, 0, 0, 1, 0, 1};
    bit            seen;
    int            d0;

    weight_fetch_ctrl dut (
        .CLK       (clk),
        .RST_N     (rst_n),
        .START     (start),
        .BASE      (base),
        .COUNT     (count),
        .BRAM_ADDR (bram_addr),
        .BRAM_EN   (bram_en),
        .BRAM_WE   (bram_we),
        .BRAM_DO   (bram_do),
        .W_DATA    (w_data),
        .W_VALID   (w_valid),
        .W_READY   (w_ready),
        .W_LAST    (w_last),
        .BUSY      (busy),
        .DONE      (done)
`ifdef WFETCH_RANGE_CHECK_EN
        ,
        .ERR       (err)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // BRAM samples on the falling edge, so its output is valid at the next rising edge.
    always @(negedge clk) begin
        if (bram_en) bram_do <= (int'(bram_addr) < DEPTH) ? mem[bram_addr] : '0;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Stream monitor: logs handshakes and issues, checks stall stability and the FIFO credit limit.
    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            model_occ    = 0;
            stalled_prev = 0;
        end else begin
            if (bram_en) begin
                check("credit_below_4", model_occ < 4, 1);
                addr_q.push_back(bram_addr);
                en_cnt++;
            end
            if (stalled_prev) begin
                check("stall_valid", w_valid, 1);
                check("stall_data", w_data, prev_data);
            end
            if (w_valid && w_ready) begin
                got_q.push_back(w_data);
                last_q.push_back(w_last);
                pop_cyc.push_back(cyc);
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            model_occ    = model_occ + int'(bram_en) - int'(w_valid && w_ready);
            stalled_prev = w_valid && !w_ready;
            prev_data    = w_data;
        end
    end

    task automatic clear_log();
        got_q.delete();
        last_q.delete();
        pop_cyc.delete();
        addr_q.delete();
        en_cnt = 0;
    endtask

    task automatic start_req(input int b, input int c);
        @(posedge clk); #1;
        start = 1'b1;
        base  = AW'(b);
        count = (AW+1)'(c);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic run_until_done(input int budget, input bit bp);
        int  base_done = done_cnt;
        bit  hit       = 0;
        for (int k = 0; k < budget && !hit; k++) begin
            @(posedge clk); #1;
            if (bp) w_ready = bp_pat[k % 6];
            @(negedge clk); #1;
            if (done_cnt != base_done) hit = 1;
        end
        check("done_seen", hit, 1);
        w_ready = 1'b1;
    endtask

    task automatic expect_stream(input int b, input int n);
        check("word_count", got_q.size(), n);
        check("addr_count", addr_q.size(), n);
        for (int i = 0; i < n && i < got_q.size(); i++) begin
            check("word_data", got_q[i], 32'h0100 + ((b + i) % DEPTH));
            check("word_last", last_q[i], (i == n - 1));
        end
        for (int i = 0; i < n && i < addr_q.size(); i++)
            check("bram_addr", addr_q[i], (b + i) % DEPTH);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n   = 1'b1;
        start   = 1'b0;
        base    = '0;
        count   = '0;
        w_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) mem[i] = 16'h0100 + DW'(i);

        // Reset values
        #2 rst_n = 1'b0;
        #1;
        check("rst_addr", bram_addr, 0);
        check("rst_en", bram_en, 0);
        check("rst_we", bram_we, 0);
        check("rst_valid", w_valid, 0);
        check("rst_last", w_last, 0);
        check("rst_data", w_data, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
`ifdef WFETCH_RANGE_CHECK_EN
        check("rst_err", err, 0);
`endif
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Basic full-depth fetch at full throughput
        clear_log();
        d0 = done_cnt;
        start_req(0, 28);
        check("busy_after_start", busy, 1);
        check("no_valid_yet", w_valid, 0);
        @(posedge clk); #1;
        check("first_valid", w_valid, 1);
        check("first_data", w_data, 16'h0100);
        run_until_done(60, 0);
        check("busy_in_fin", busy, 0);
        expect_stream(0, 28);
        if (pop_cyc.size() == 28) begin
            check("back_to_back", pop_cyc[27] - pop_cyc[0], 27);
            check("done_after_last", done_cyc, pop_cyc[27] + 1);
        end
        @(negedge clk); #1;
        check("done_one_cycle", done, 0);
        check("basic_done_cnt", done_cnt - d0, 1);

        // Backpressure with an irregular ready pattern
        clear_log();
        d0 = done_cnt;
        start_req(3, 6);
        run_until_done(80, 1);
        expect_stream(3, 6);
        check("bp_done_cnt", done_cnt - d0, 1);

        // Zero-length request
        clear_log();
        d0 = done_cnt;
        start_req(0, 0);
        @(negedge clk); #1;
        check("zero_done", done, 1);
        check("zero_busy", busy, 0);
        @(negedge clk); #1;
        check("zero_done_drop", done, 0);
        repeat (3) @(negedge clk);
        #1;
        check("zero_no_en", en_cnt, 0);
        check("zero_no_words", got_q.size(), 0);
        check("zero_done_cnt", done_cnt - d0, 1);

        // Request crossing the top of the weight array
        clear_log();
        d0 = done_cnt;
        start_req(26, 4);
`ifdef WFETCH_RANGE_CHECK_EN
        @(negedge clk); #1;
        check("range_done", done, 1);
        check("range_err", err, 1);
        repeat (3) @(negedge clk);
        #1;
        check("range_err_sticky", err, 1);
        check("range_no_en", en_cnt, 0);
        check("range_no_words", got_q.size(), 0);
        check("range_done_cnt", done_cnt - d0, 1);
`else
        run_until_done(40, 0);
        expect_stream(26, 4);
        check("wrap_done_cnt", done_cnt - d0, 1);
`endif

        // START while busy is ignored
        clear_log();
        d0 = done_cnt;
        start_req(0, 8);
`ifdef WFETCH_RANGE_CHECK_EN
        check("err_cleared", err, 0);
`endif
        @(posedge clk); #1;
        start = 1'b1;
        base  = 5'd10;
        count = 6'd3;
        @(posedge clk); #1;
        start = 1'b0;
        check("busy_while_ignored", busy, 1);
        run_until_done(60, 0);
        expect_stream(0, 8);
        repeat (3) @(negedge clk);
        #1;
        check("ignored_done_cnt", done_cnt - d0, 1);

        // Reset in the middle of a request
        clear_log();
        d0 = done_cnt;
        start_req(0, 20);
        seen = 0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk); #1;
            if (got_q.size() >= 3) seen = 1;
        end
        check("third_word_seen", seen, 1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_en", bram_en, 0);
        check("mid_rst_addr", bram_addr, 0);
        check("mid_rst_valid", w_valid, 0);
        check("mid_rst_last", w_last, 0);
        check("mid_rst_data", w_data, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("mid_rst_no_done", done_cnt - d0, 0);

        clear_log();
        d0 = done_cnt;
        start_req(0, 2);
        run_until_done(20, 0);
        expect_stream(0, 2);
        check("post_rst_done_cnt", done_cnt - d0, 1);

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
